dcache_ctrl: RTL and testbench

Miss/refill and write-through controller for the 64-entry direct-mapped data cache in the RISC-V core. It sits between the CPU load/store port, the cache line array (57-bit lines: valid, 24-bit tag, 32-bit word) and main memory. It decides hit or miss, stalls the CPU, and refills lines over a req/ack memory handshake. It also invalidates every line after reset or on a flush request, and keeps hit/miss counters.

---
 rtl/dcache_pkg.sv | 34 +++
 rtl/dcache_ctrl_if.sv | 47 ++++
 rtl/dcache_perf_ctr.sv | 29 ++
 rtl/dcache_ctrl.sv | 130 +++++++++++++
 tb/tb_dcache_ctrl.sv | 328 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dcache_pkg.sv
// Shared types, line-field positions and address helpers for the direct-mapped
// data cache controller.
package dcache_pkg;

    localparam int ADDR_W    = 32;
    localparam int DATA_W    = 32;
    localparam int IDX_W     = 6;
    localparam int LINE_W    = 57;
    localparam int NUM_LINES = 1 << IDX_W;
    localparam int TAG_WIDTH = ADDR_W - 2 - IDX_W;

    localparam int VALID_BIT = 56;
    localparam int TAG_MSB   = 55;
    localparam int TAG_LSB   = 32;
    localparam int DATA_MSB  = 31;

    typedef enum logic [2:0] {
        S_FLUSH  = 3'd0,
        S_IDLE   = 3'd1,
        S_REFILL = 3'd2,
        S_WRITE  = 3'd3,
        S_RESP   = 3'd4
    } dcache_state_t;

    function automatic logic [TAG_WIDTH-1:0] tag_of(input logic [ADDR_W-1:0] addr);
        return TAG_WIDTH'(addr >> (ADDR_W - TAG_WIDTH));
    endfunction

    // Word-aligned addresses: the two byte-offset bits never select a line.
    function automatic logic [IDX_W-1:0] idx_of(input logic [ADDR_W-1:0] addr);
        return IDX_W'(addr >> 2);
    endfunction

endpackage

// File: rtl/dcache_ctrl_if.sv
// Bus bundle joining the cache controller to the CPU load/store port, the line
// array and main memory; master is the controller's view.
interface dcache_ctrl_if
    import dcache_pkg::*;
#(
    parameter int ADDR_WIDTH          = ADDR_W,
    parameter int DATA_WIDTH          = DATA_W,
    parameter int CACHE_ADDRESS_WIDTH = IDX_W,
    parameter int CACHE_DATA_WIDTH    = LINE_W
);
    logic                           cpu_req;
    logic                           cpu_we;
    logic [ADDR_WIDTH-1:0]          cpu_addr;
    logic [DATA_WIDTH-1:0]          cpu_wdata;
    logic [DATA_WIDTH-1:0]          cpu_rdata;
    logic                           cpu_stall;
    logic                           flush;

    logic [CACHE_ADDRESS_WIDTH-1:0] cache_idx;
    logic [CACHE_DATA_WIDTH-1:0]    cache_line;
    logic                           cache_we;
    logic [CACHE_DATA_WIDTH-1:0]    cache_wline;

    logic                           mem_req;
    logic                           mem_we;
    logic [ADDR_WIDTH-1:0]          mem_addr;
    logic [DATA_WIDTH-1:0]          mem_wdata;
    logic                           mem_ack;
    logic [DATA_WIDTH-1:0]          mem_rdata;

    logic [31:0]                    hit_count;
    logic [31:0]                    miss_count;

    modport master (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata, flush,
        input  cache_line, mem_ack, mem_rdata,
        output cpu_rdata, cpu_stall, cache_idx, cache_we, cache_wline,
        output mem_req, mem_we, mem_addr, mem_wdata, hit_count, miss_count
    );

    modport slave (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata, flush,
        output cache_line, mem_ack, mem_rdata,
        input  cpu_rdata, cpu_stall, cache_idx, cache_we, cache_wline,
        input  mem_req, mem_we, mem_addr, mem_wdata, hit_count, miss_count
    );
endinterface

// File: rtl/dcache_perf_ctr.sv
// Load hit/miss event counters; both wrap silently at 2^WIDTH.
module dcache_perf_ctr
    import dcache_pkg::*;
#(
    parameter int WIDTH = DATA_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_hit_inc,
    input  logic             i_miss_inc,
    output logic [WIDTH-1:0] o_hit_count,
    output logic [WIDTH-1:0] o_miss_count
);
    logic [WIDTH-1:0] r_hit;
    logic [WIDTH-1:0] r_miss;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_hit  <= '0;
            r_miss <= '0;
        end else begin
            if (i_hit_inc)  r_hit  <= r_hit + WIDTH'(1);
            if (i_miss_inc) r_miss <= r_miss + WIDTH'(1);
        end
    end

    assign o_hit_count  = r_hit;
    assign o_miss_count = r_miss;
endmodule

// File: rtl/dcache_ctrl.sv
// Miss/refill and write-through controller for the 64-line direct-mapped data
// cache: hit detection, CPU stall, memory handshake and full-cache invalidate.
module dcache_ctrl
    import dcache_pkg::*;
#(
    parameter int ADDR_WIDTH          = ADDR_W,
    parameter int DATA_WIDTH          = DATA_W,
    parameter int CACHE_ADDRESS_WIDTH = IDX_W,
    parameter int CACHE_DATA_WIDTH    = LINE_W
) (
    input  logic          clk,
    input  logic          rst_n,
    dcache_ctrl_if.master bus
);
    dcache_state_t                  r_state;
    dcache_state_t                  w_next;
    logic [CACHE_ADDRESS_WIDTH-1:0] r_sweep;
    logic                           r_flush_pend;
    logic                           r_mem_req;
    logic                           r_mem_we;
    logic [DATA_WIDTH-1:0]          r_rdata;

    logic [ADDR_WIDTH-1:0]          w_addr;
    logic [TAG_WIDTH-1:0]           w_tag;
    logic                           w_hit;
    logic                           w_idle_load;
    logic                           w_cache_we;
    logic [CACHE_DATA_WIDTH-1:0]    w_wline;
    logic [CACHE_ADDRESS_WIDTH-1:0] w_idx;
    logic                           w_stall;
    logic [DATA_WIDTH-1:0]          w_cpu_rdata;

    assign w_addr = bus.cpu_addr;
    assign w_tag  = tag_of(w_addr);
    assign w_hit  = bus.cache_line[VALID_BIT] && (bus.cache_line[TAG_MSB:TAG_LSB] == w_tag);

    // A flush in IDLE pre-empts any request presented in the same cycle.
    assign w_idle_load = (r_state == S_IDLE) && !bus.flush && bus.cpu_req && !bus.cpu_we;

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= S_FLUSH;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_FLUSH:  if (&r_sweep) w_next = S_IDLE;
            S_IDLE: begin
                if (bus.flush)                w_next = S_FLUSH;
                else if (bus.cpu_req) begin
                    if (bus.cpu_we)           w_next = S_WRITE;
                    else if (!w_hit)          w_next = S_REFILL;
                end
            end
            S_REFILL: if (bus.mem_ack) w_next = S_RESP;
            S_WRITE:  if (bus.mem_ack) w_next = S_RESP;
            S_RESP:   w_next = (r_flush_pend || bus.flush) ? S_FLUSH : S_IDLE;
            default:  w_next = S_FLUSH;
        endcase
    end

    always_comb begin
        w_cache_we  = 1'b0;
        w_wline     = '0;
        w_stall     = 1'b1;
        w_cpu_rdata = r_rdata;
        w_idx       = idx_of(w_addr);
        case (r_state)
            S_FLUSH: begin
                w_cache_we = 1'b1;
                w_idx      = r_sweep;
            end
            S_IDLE: begin
                w_stall     = bus.flush || (bus.cpu_req && (bus.cpu_we || !w_hit));
                w_cpu_rdata = bus.cache_line[DATA_MSB:0];
            end
            S_REFILL: begin
                w_cache_we = bus.mem_ack;
                w_wline    = {1'b1, w_tag, bus.mem_rdata};
            end
            S_WRITE: begin
                w_cache_we = bus.mem_ack && w_hit;
                w_wline    = {1'b1, w_tag, bus.cpu_wdata};
            end
            S_RESP:  w_stall = 1'b0;
            default: ;
        endcase
    end

    // Memory strobes are registered off the next state so they never glitch.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sweep      <= '0;
            r_flush_pend <= 1'b0;
            r_mem_req    <= 1'b0;
            r_mem_we     <= 1'b0;
            r_rdata      <= '0;
        end else begin
            r_sweep   <= (r_state == S_FLUSH) ? r_sweep + CACHE_ADDRESS_WIDTH'(1) : '0;
            r_mem_req <= (w_next == S_REFILL) || (w_next == S_WRITE);
            r_mem_we  <= (w_next == S_WRITE);
            if (w_next == S_FLUSH)
                r_flush_pend <= 1'b0;
            else if (bus.flush && (r_state == S_REFILL || r_state == S_WRITE || r_state == S_RESP))
                r_flush_pend <= 1'b1;
            if (r_state == S_REFILL && bus.mem_ack)
                r_rdata <= bus.mem_rdata;
        end
    end

    dcache_perf_ctr #(.WIDTH(32)) u_perf (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_hit_inc    (w_idle_load && w_hit),
        .i_miss_inc   (w_idle_load && !w_hit),
        .o_hit_count  (bus.hit_count),
        .o_miss_count (bus.miss_count)
    );

    assign bus.cache_we    = w_cache_we && rst_n;
    assign bus.cache_wline = w_wline;
    assign bus.cache_idx   = w_idx;
    assign bus.cpu_stall   = w_stall;
    assign bus.cpu_rdata   = w_cpu_rdata;
    assign bus.mem_req     = r_mem_req;
    assign bus.mem_we      = r_mem_we;
    assign bus.mem_addr    = w_addr;
    assign bus.mem_wdata   = bus.cpu_wdata;
endmodule

// File: tb/tb_dcache_ctrl.sv
// Self-checking bench for dcache_ctrl: line array and memory models around the
// DUT, plus a tag/valid + shadow-memory reference of expected cache behaviour.
module tb_dcache_ctrl;
    import dcache_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    dcache_ctrl_if bus ();
    dcache_ctrl dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int checks = 0;
    int errors = 0;

    logic [56:0] lineArr [64];
    int          cacheWeCount = 0;
    assign bus.cache_line = lineArr[bus.cache_idx];

    // Line array starts full of garbage so the reset sweep has something to clear.
    initial begin
        for (int i = 0; i < 64; i++) lineArr[i] = 57'({$urandom, $urandom});
        forever begin
            @(posedge clk);
            if (bus.cache_we === 1'b1) begin
                lineArr[bus.cache_idx] <= bus.cache_wline;
                cacheWeCount++;
            end
        end
    end

    logic [31:0] memStore [logic [31:0]];
    int          ackDelay = 1;
    int          waitCnt = 0;
    int          memTxns = 0;
    logic [31:0] lastMemAddr, lastMemWdata;
    logic        lastMemWe;

    function automatic logic [31:0] memInit(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    // Memory acks on the ackDelay-th cycle of a held request.
    initial begin
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = '0;
        forever begin
            @(negedge clk);
            bus.mem_ack = 1'b0;
            if (bus.mem_req === 1'b1) begin
                waitCnt++;
                if (waitCnt == ackDelay) begin
                    bus.mem_ack  = 1'b1;
                    lastMemAddr  = bus.mem_addr;
                    lastMemWe    = bus.mem_we;
                    lastMemWdata = bus.mem_wdata;
                    memTxns++;
                    if (bus.mem_we) memStore[bus.mem_addr] = bus.mem_wdata;
                    else bus.mem_rdata = memStore.exists(bus.mem_addr) ? memStore[bus.mem_addr] : memInit(bus.mem_addr);
                end
            end else begin
                waitCnt = 0;
            end
        end
    end

    logic [31:0] shadow [logic [31:0]];
    bit          resValid [64];
    logic [23:0] resTag [64];
    int          expHits = 0;
    int          expMisses = 0;

    function automatic logic [31:0] shadowRead(input logic [31:0] a);
        return shadow.exists(a) ? shadow[a] : memInit(a);
    endfunction

    task automatic clearModel();
        for (int i = 0; i < 64; i++) resValid[i] = 1'b0;
    endtask

    task automatic cpuOp(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         output int stallCycles, output logic [31:0] rdata, output logic timedOut);
        @(negedge clk);
        bus.cpu_req = 1'b1; bus.cpu_we = we; bus.cpu_addr = addr; bus.cpu_wdata = wdata;
        stallCycles = 0;
        timedOut = 1'b0;
        #1;
        while (bus.cpu_stall !== 1'b0) begin
            @(posedge clk); #1;
            stallCycles++;
            if (stallCycles > 200) begin timedOut = 1'b1; break; end
        end
        rdata = bus.cpu_rdata;
        @(posedge clk); #1;
        bus.cpu_req = 1'b0;
    endtask

    task automatic modelOp(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                           input int delay, input string name);
        int idx, expStall, stallC, txnsBefore;
        logic [23:0] t;
        logic [31:0] rd;
        logic tmo;
        bit expHit;
        idx = int'(addr[7:2]);
        t = addr[31:8];
        expHit = !we && resValid[idx] && (resTag[idx] == t);
        expStall = expHit ? 0 : 1 + delay;
        ackDelay = delay;
        txnsBefore = memTxns;
        cpuOp(we, addr, wdata, stallC, rd, tmo);
        checks++;
        if (tmo || stallC != expStall) begin
            errors++;
            $display("[TB] FAIL %s stall: got %0d cycles (timeout=%b), expected %0d", name, stallC, tmo, expStall);
        end
        if (!we) begin
            checks++;
            if (rd !== shadowRead(addr)) begin
                errors++;
                $display("[TB] FAIL %s rdata @%h: got %h, expected %h", name, addr, rd, shadowRead(addr));
            end
            if (expHit) expHits++;
            else begin expMisses++; resValid[idx] = 1'b1; resTag[idx] = t; end
        end else begin
            shadow[addr] = wdata;
            checks++;
            if (lastMemAddr !== addr || lastMemWe !== 1'b1 || lastMemWdata !== wdata) begin
                errors++;
                $display("[TB] FAIL %s memwrite: got addr=%h we=%b data=%h, expected addr=%h we=1 data=%h",
                         name, lastMemAddr, lastMemWe, lastMemWdata, addr, wdata);
            end
        end
        checks++;
        if (bus.hit_count !== 32'(expHits) || bus.miss_count !== 32'(expMisses)) begin
            errors++;
            $display("[TB] FAIL %s counters: got hit=%0d miss=%0d, expected hit=%0d miss=%0d",
                     name, bus.hit_count, bus.miss_count, expHits, expMisses);
        end
        checks++;
        if (memTxns - txnsBefore != (expHit ? 0 : 1)) begin
            errors++;
            $display("[TB] FAIL %s memtxns: got %0d, expected %0d", name, memTxns - txnsBefore, expHit ? 0 : 1);
        end
    endtask

    task automatic checkSweep(input string name);
        int bad;
        for (int i = 0; i < 64; i++) begin
            checks++;
            if (bus.cache_we !== 1'b1 || bus.cache_idx !== 6'(i) || bus.cache_wline !== '0 || bus.cpu_stall !== 1'b1) begin
                errors++;
                $display("[TB] FAIL %s sweep[%0d]: got we=%b idx=%0d wline=%h stall=%b, expected we=1 idx=%0d wline=0 stall=1",
                         name, i, bus.cache_we, bus.cache_idx, bus.cache_wline, bus.cpu_stall, i);
            end
            @(posedge clk); #1;
        end
        checks++;
        if (bus.cpu_stall !== 1'b0 || bus.cache_we !== 1'b0) begin
            errors++;
            $display("[TB] FAIL %s sweep end: got stall=%b we=%b, expected stall=0 we=0", name, bus.cpu_stall, bus.cache_we);
        end
        bad = 0;
        for (int i = 0; i < 64; i++) if (lineArr[i][VALID_BIT] !== 1'b0) bad++;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("[TB] FAIL %s lines valid after sweep: got %0d, expected 0", name, bad);
        end
        clearModel();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (bus.cache_we !== 1'b0 || bus.mem_req !== 1'b0 || bus.mem_we !== 1'b0 || bus.cpu_stall !== 1'b1 ||
            bus.hit_count !== 32'd0 || bus.miss_count !== 32'd0) begin
            errors++;
            $display("[TB] FAIL reset: got we=%b mreq=%b mwe=%b stall=%b hit=%0d miss=%0d, expected 0 0 0 1 0 0",
                     bus.cache_we, bus.mem_req, bus.mem_we, bus.cpu_stall, bus.hit_count, bus.miss_count);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkSweep("reset");
        expHits = 0;
        expMisses = 0;
    endtask

    task automatic test_load_miss_hit();
        memStore[32'h104] = 32'hDEAD_BEEF;
        shadow[32'h104]   = 32'hDEAD_BEEF;
        modelOp(1'b0, 32'h0000_0104, '0, 3, "load miss");
        checks++;
        if (lineArr[1] !== {1'b1, 24'h000001, 32'hDEAD_BEEF}) begin
            errors++;
            $display("[TB] FAIL refill line: got %h, expected %h", lineArr[1], {1'b1, 24'h000001, 32'hDEAD_BEEF});
        end
        modelOp(1'b0, 32'h0000_0104, '0, 1, "load hit");
    endtask

    task automatic test_conflict();
        modelOp(1'b0, 32'h0000_0204, '0, 2, "conflict miss");
        checks++;
        if (lineArr[1] !== {1'b1, 24'h000002, shadowRead(32'h204)}) begin
            errors++;
            $display("[TB] FAIL conflict line: got %h, expected %h", lineArr[1], {1'b1, 24'h000002, shadowRead(32'h204)});
        end
    endtask

    task automatic test_store();
        int weBefore;
        modelOp(1'b1, 32'h0000_0204, 32'h1234_5678, 1, "store hit");
        checks++;
        if (lineArr[1] !== {1'b1, 24'h000002, 32'h1234_5678}) begin
            errors++;
            $display("[TB] FAIL store line: got %h, expected %h", lineArr[1], {1'b1, 24'h000002, 32'h1234_5678});
        end
        weBefore = cacheWeCount;
        modelOp(1'b1, 32'h0000_1014, 32'hCAFE_F00D, 2, "store uncached");
        checks++;
        if (cacheWeCount != weBefore) begin
            errors++;
            $display("[TB] FAIL store uncached cache_we: got %0d writes, expected 0", cacheWeCount - weBefore);
        end
        modelOp(1'b0, 32'h0000_0204, '0, 1, "load after store");
        modelOp(1'b0, 32'h0000_1014, '0, 2, "load written-through");
    endtask

    task automatic test_flush_idle();
        int hitsBefore;
        hitsBefore = expHits;
        @(negedge clk);
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 32'h0000_0204; bus.flush = 1'b1;
        #1;
        checks++;
        if (bus.cpu_stall !== 1'b1) begin
            errors++;
            $display("[TB] FAIL flush idle stall: got %b, expected 1", bus.cpu_stall);
        end
        @(posedge clk); #1;
        bus.flush = 1'b0; bus.cpu_req = 1'b0;
        checks++;
        if (bus.hit_count !== 32'(hitsBefore)) begin
            errors++;
            $display("[TB] FAIL flush idle hit_count: got %0d, expected %0d", bus.hit_count, hitsBefore);
        end
        checkSweep("flush idle");
    endtask

    task automatic test_flush_refill();
        fork
            modelOp(1'b0, 32'h0000_0204, '0, 4, "flush refill");
            begin
                repeat (3) @(negedge clk);
                bus.flush = 1'b1;
                @(negedge clk);
                bus.flush = 1'b0;
            end
        join
        checkSweep("flush refill");
        modelOp(1'b0, 32'h0000_0204, '0, 1, "miss after flush");
    endtask

    task automatic test_random();
        for (int n = 0; n < 60; n++) begin
            logic we;
            logic [31:0] addr;
            we = ($urandom_range(0, 2) == 0);
            addr = {24'($urandom_range(0, 3)), 6'($urandom_range(0, 7)), 2'b00};
            modelOp(we, addr, $urandom, $urandom_range(1, 4), "random");
        end
    endtask

    task automatic test_reset_mid_write();
        ackDelay = 1000;
        @(negedge clk);
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 32'h0000_0308; bus.cpu_wdata = 32'h0BAD_CAFE;
        @(posedge clk); #1;
        checks++;
        if (bus.mem_req !== 1'b1 || bus.mem_we !== 1'b1) begin
            errors++;
            $display("[TB] FAIL write pending: got mem_req=%b mem_we=%b, expected 1 1", bus.mem_req, bus.mem_we);
        end
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (bus.mem_req !== 1'b0 || bus.hit_count !== 32'd0 || bus.miss_count !== 32'd0 ||
            bus.cache_we !== 1'b0 || bus.cpu_stall !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset mid write: got mem_req=%b hit=%0d miss=%0d we=%b stall=%b, expected 0 0 0 0 1",
                     bus.mem_req, bus.hit_count, bus.miss_count, bus.cache_we, bus.cpu_stall);
        end
        @(negedge clk);
        rst_n = 1'b1;
        bus.cpu_req = 1'b0;
        #1;
        checkSweep("reset mid write");
        ackDelay = 1;
        expHits = 0;
        expMisses = 0;
        modelOp(1'b0, 32'h0000_0104, '0, 2, "load after reset");
    endtask

    initial begin
        bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0; bus.flush = 1'b0;
        clearModel();
        test_reset();
        test_load_miss_hit();
        test_conflict();
        test_store();
        test_flush_idle();
        test_flush_refill();
        test_random();
        test_reset_mid_write();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "[TB] watchdog expired");
    end
endmodule
